// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the writeback port arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } wb_arb_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dst_reg;
        logic        live;
    } llu_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_llu_fifo.sv
// rtl/wb_llu_fifo.sv - circular LLU result buffer with parallel register-match live-clear
module wb_llu_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  llu_entry_t      push_entry,
    input  logic            pop,
    input  logic            kill_en,
    input  logic [4:0]      kill_reg,
    output llu_entry_t      head,
    output logic [CW-1:0]   count,
    output logic            empty
);

    llu_entry_t    mem_q [DEPTH];
    llu_entry_t    mem_d [DEPTH];
    llu_entry_t    new_entry;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d     = mem_q;
        new_entry = push_entry;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        // A pipeline write supersedes every older result bound for the same register
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && (mem_q[i].dst_reg == kill_reg)) begin
                mem_d[i].live = 1'b0;
            end
        end
        if (kill_en && (push_entry.dst_reg == kill_reg)) begin
            new_entry.live = 1'b0;
        end
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register file write port arbiter, pipeline vs. queued LLU results
// Optional starvation guard (counter + FORCE stall) built when WB_ARB_STARVE_EN is defined.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   WbData,
    input  logic [4:0]    WbReg,
    input  logic          WbWrite,
    input  logic          LluValid,
    output logic          LluReady,
    input  logic [31:0]   LluData,
    input  logic [4:0]    LluReg,
    output logic [31:0]   RfWriteData,
    output logic [4:0]    RfWriteReg,
    output logic          RfWrite,
    output logic          PipeStall,
    output logic [CW-1:0] QueueCount
);

    llu_entry_t    push_entry;
    llu_entry_t    head;
    logic [CW-1:0] count;
    logic          empty;
    logic          llu_ready;
    logic          push, pop;
    logic          pipe_want, pipe_grant;
    logic          head_live, head_grant;
    logic          pipe_stall;

    assign llu_ready  = (count < CW'(DEPTH));
    assign push       = LluValid && llu_ready;
    assign push_entry = '{data: LluData, dst_reg: LluReg, live: (LluReg != REG_ZERO)};

    // During a forced drain the pipeline write is dropped; upstream re-presents it
    assign pipe_want  = WbWrite && (WbReg != REG_ZERO);
    assign pipe_grant = pipe_want && !pipe_stall;
    assign head_live  = !empty && head.live;
    assign head_grant = head_live && !pipe_grant;
    assign pop        = !empty && (head_grant || !head.live);

    wb_llu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (pipe_grant),
        .kill_reg   (WbReg),
        .head       (head),
        .count      (count),
        .empty      (empty)
    );

`ifdef WB_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

    wb_arb_state_e state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [CW-1:0] count_nxt;

    assign count_nxt = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                starve_d = '0;
                state_d  = (count_nxt != '0) ? PEND : IDLE;
            end
            PEND: begin
                if (pop) begin
                    starve_d = '0;
                end else if (head_live && !head_grant) begin
                    starve_d = starve_q + 1'b1;
                end
                if (count_nxt == '0) begin
                    state_d  = IDLE;
                    starve_d = '0;
                end else if (starve_d == STARVE_MAX) begin
                    state_d = FORCE;
                end
            end
            FORCE: begin
                starve_d = '0;
                state_d  = (count_nxt != '0) ? PEND : IDLE;
            end
            default: begin
                state_d  = IDLE;
                starve_d = '0;
            end
        endcase
    end

    always_comb begin
        pipe_stall = (state_q == FORCE);
    end
`else
    assign pipe_stall = 1'b0;
`endif

    always_comb begin
        RfWrite     = pipe_grant || head_grant;
        RfWriteReg  = REG_ZERO;
        RfWriteData = '0;
        if (pipe_grant) begin
            RfWriteReg  = WbReg;
            RfWriteData = WbData;
        end else if (head_grant) begin
            RfWriteReg  = head.dst_reg;
            RfWriteData = head.data;
        end
    end

    assign LluReady   = llu_ready;
    assign PipeStall  = pipe_stall;
    assign QueueCount = count;

endmodule
